// File: rtl/watermark_stream_if.sv
// Stream bundle for the watermark composer: input beat, config, output beat.
// Slave is the composer's view, master is the producer/consumer view.
interface watermark_stream_if #(
  parameter int LANES = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_seg;
  logic [LANES-1:0] in_wm;
  logic [1:0]       cfg_mode;
  logic             cfg_noise_en;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_pix;
  logic             out_last;
  logic             frame_done;
  logic [15:0]      frame_count;

  modport slave (
    input  in_valid, in_seg, in_wm,
    input  cfg_mode, cfg_noise_en, out_ready,
    output in_ready, out_valid, out_pix,
    output out_last, frame_done, frame_count
  );

  modport master (
    output in_valid, in_seg, in_wm,
    output cfg_mode, cfg_noise_en, out_ready,
    input  in_ready, out_valid, out_pix,
    input  out_last, frame_done, frame_count
  );
endinterface

// File: rtl/watermark_stream.sv
// Streaming segment/watermark composer with per-frame mode and LFSR noise.
// One output register stage; full throughput with valid/ready backpressure.
module watermark_stream #(
  parameter int          WIDTH     = 224,
  parameter int          HEIGHT    = 96,
  parameter int          LANES     = 32,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input logic               clk,
  input logic               rst,
  watermark_stream_if.slave bus
);
  localparam int BEATS = (WIDTH * HEIGHT) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);
  localparam logic [31:0]   TAPS     = 32'h80200003;

  logic [BW-1:0]    r_beat;
  logic [31:0]      r_lfsr;
  logic [1:0]       r_mode;
  logic             r_noise;
  logic             r_valid;
  logic [LANES-1:0] r_pix;
  logic             r_last;
  logic [15:0]      r_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_first;
  logic             w_last_beat;
  logic [1:0]       w_mode;
  logic             w_noise;
  logic [LANES-1:0] w_comp;
  logic [LANES-1:0] w_mask;
  logic [LANES-1:0] w_pix;
  logic [31:0]      w_lfsr_nxt;

  assign w_in_ready  = !r_valid || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_out_hs    = r_valid && bus.out_ready;
  assign w_first     = (r_beat == '0);
  assign w_last_beat = (r_beat == LAST_IDX);

  // First beat of a frame uses the live config; later beats the latched one.
  assign w_mode  = w_first ? bus.cfg_mode : r_mode;
  assign w_noise = w_first ? bus.cfg_noise_en : r_noise;

  assign w_mask     = r_lfsr[LANES-1:0] & {LANES{w_noise}};
  assign w_pix      = w_comp ^ w_mask;
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'h0);

  // Per-lane composition of segment and watermark pixels.
  always_comb begin
    w_comp = bus.in_seg | bus.in_wm;
    case (w_mode)
      2'd0:    w_comp = bus.in_seg | bus.in_wm;
      2'd1:    w_comp = bus.in_seg ^ bus.in_wm;
      2'd2:    w_comp = bus.in_seg & ~bus.in_wm;
      default: w_comp = bus.in_seg;
    endcase
  end

  // Output register, beat position, config latch, noise LFSR, frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat  <= '0;
      r_lfsr  <= LFSR_SEED;
      r_mode  <= 2'd0;
      r_noise <= 1'b0;
      r_valid <= 1'b0;
      r_pix   <= '0;
      r_last  <= 1'b0;
      r_count <= 16'd0;
    end else begin
      if (w_out_hs && r_last)
        r_count <= r_count + 16'd1;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pix   <= w_pix;
        r_last  <= w_last_beat;
        r_lfsr  <= w_lfsr_nxt;
        r_beat  <= w_last_beat ? '0 : r_beat + 1'b1;
        if (w_first) begin
          r_mode  <= bus.cfg_mode;
          r_noise <= bus.cfg_noise_en;
        end
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.out_pix     = r_pix;
  assign bus.out_last    = r_last;
  assign bus.frame_done  = w_out_hs && r_last;
  assign bus.frame_count = r_count;
endmodule

// File: tb/tb_watermark_stream.sv
// Bench for watermark_stream: directed frames on a 4x2/4-lane instance,
// randomized traffic vs a reference model, and count wrap on a 1-beat instance.
module tb_watermark_stream;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic obs_rdy;
  logic obs_done;

  watermark_stream_if #(.LANES(4)) bus_a ();
  watermark_stream_if #(.LANES(8)) bus_b ();

  watermark_stream #(
    .WIDTH(4), .HEIGHT(2), .LANES(4), .LFSR_SEED(32'h1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  watermark_stream #(
    .WIDTH(4), .HEIGHT(2), .LANES(8), .LFSR_SEED(32'h1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [3:0] ref_comp(
    input logic [1:0] m, input logic [3:0] s, input logic [3:0] w);
    case (m)
      2'd0:    return s | w;
      2'd1:    return s ^ w;
      2'd2:    return s & ~w;
      default: return s;
    endcase
  endfunction

  // Drive one cycle on instance A; sample combinational outputs pre-edge.
  task automatic step(input logic iv, input logic [3:0] s, input logic [3:0] w,
                      input logic [1:0] m, input logic ne, input logic ordy);
    bus_a.in_valid     = iv;
    bus_a.in_seg       = s;
    bus_a.in_wm        = w;
    bus_a.cfg_mode     = m;
    bus_a.cfg_noise_en = ne;
    bus_a.out_ready    = ordy;
    #1;
    obs_rdy  = bus_a.in_ready;
    obs_done = bus_a.frame_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic seen_done;
    logic rdy_low;
    seen_done = 1'b0;
    rdy_low   = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
      if (obs_done) seen_done = 1'b1;
      if (!obs_rdy) rdy_low = 1'b1;
    end
    n_checks++;
    if (bus_a.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid got %b want 0", bus_a.out_valid);
    end
    n_checks++;
    if (rdy_low !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready got low want 1");
    end
    n_checks++;
    if (bus_a.frame_count !== 16'd0) begin
      n_errors++; $display("FAIL reset_count got %0d want 0", bus_a.frame_count);
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_done got pulse want none");
    end
    n_checks++;
    if (bus_a.out_pix !== 4'h0 || bus_a.out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pix got %b/%b want 0000/0", bus_a.out_pix, bus_a.out_last);
    end
    n_checks++;
    if (bus_b.frame_count !== 16'd0 || bus_b.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_b got %0d/%b want 0/0", bus_b.frame_count, bus_b.out_valid);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 4'b0011, 4'b0101, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_pix !== 4'b0111 ||
        bus_a.out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_b0 got v%b p%b l%b want v1 p0111 l0",
               bus_a.out_valid, bus_a.out_pix, bus_a.out_last);
    end
    step(1'b1, 4'b1000, 4'b0001, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_pix !== 4'b1001 ||
        bus_a.out_last !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_b1 got v%b p%b l%b want v1 p1001 l1",
               bus_a.out_valid, bus_a.out_pix, bus_a.out_last);
    end
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_done !== 1'b1) begin
      n_errors++; $display("FAIL basic_done got %b want 1", obs_done);
    end
    n_checks++;
    if (bus_a.frame_count !== 16'd1 || bus_a.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_count got %0d/v%b want 1/v0",
               bus_a.frame_count, bus_a.out_valid);
    end
  endtask

  task automatic test_modes();
    logic [3:0] want0 [3];
    logic [3:0] want1 [3];
    logic [1:0] m;
    want0[0] = 4'b0110; want0[1] = 4'b0010; want0[2] = 4'b0011;
    want1[0] = 4'b1001; want1[1] = 4'b1000; want1[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      m = 2'(i + 1);
      step(1'b1, 4'b0011, 4'b0101, m, 1'b0, 1'b1);
      n_checks++;
      if (bus_a.out_pix !== want0[i]) begin
        n_errors++;
        $display("FAIL mode%0d_b0 got %b want %b", m, bus_a.out_pix, want0[i]);
      end
      step(1'b1, 4'b1000, 4'b0001, m + 2'd1, 1'b1, 1'b1);
      n_checks++;
      if (bus_a.out_pix !== want1[i] || bus_a.out_last !== 1'b1) begin
        n_errors++;
        $display("FAIL mode%0d_latched got %b/l%b want %b/l1",
                 m, bus_a.out_pix, bus_a.out_last, want1[i]);
      end
    end
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_noise();
    logic [3:0] want [4];
    want[0] = 4'b0001; want[1] = 4'b0011;
    want[2] = 4'b0010; want[3] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h0, 4'hF, 2'd3, 1'b1, 1'b1);
      n_checks++;
      if (bus_a.out_pix !== want[i]) begin
        n_errors++;
        $display("FAIL noise_beat%0d got %b want %b", i, bus_a.out_pix, want[i]);
      end
    end
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic stall_bad;
    stall_bad = 1'b0;
    do_reset();
    step(1'b1, 4'b0001, 4'b0010, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs_rdy !== 1'b1 || bus_a.out_pix !== 4'b0011 ||
        bus_a.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first got r%b p%b want r1 p0011", obs_rdy, bus_a.out_pix);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
      if (obs_rdy !== 1'b0 || bus_a.out_pix !== 4'b0011 ||
          bus_a.out_valid !== 1'b1 || bus_a.out_last !== 1'b0)
        stall_bad = 1'b1;
    end
    n_checks++;
    if (stall_bad !== 1'b0) begin
      n_errors++; $display("FAIL bp_stall got unstable want held");
    end
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_rdy !== 1'b1 || bus_a.out_pix !== 4'b0100 ||
        bus_a.out_last !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_swap got r%b p%b l%b want r1 p0100 l1",
               obs_rdy, bus_a.out_pix, bus_a.out_last);
    end
    step(1'b1, 4'b1000, 4'b1000, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_done !== 1'b1 || bus_a.out_pix !== 4'b1000 ||
        bus_a.frame_count !== 16'd1) begin
      n_errors++;
      $display("FAIL bp_next got d%b p%b c%0d want d1 p1000 c1",
               obs_done, bus_a.out_pix, bus_a.frame_count);
    end
    step(1'b1, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_done !== 1'b1 || bus_a.out_valid !== 1'b0 ||
        bus_a.frame_count !== 16'd2) begin
      n_errors++;
      $display("FAIL bp_end got d%b v%b c%0d want d1 v0 c2",
               obs_done, bus_a.out_valid, bus_a.frame_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b0011, 4'b0101, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 4'b1000, 4'b0001, 2'd1, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.frame_count !== 16'd0) begin
      n_errors++;
      $display("FAIL rstmid_clear got v%b c%0d want v0 c0",
               bus_a.out_valid, bus_a.frame_count);
    end
    step(1'b1, 4'h0, 4'hF, 2'd3, 1'b1, 1'b1);
    n_checks++;
    if (bus_a.out_pix !== 4'b0001 || bus_a.out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_b0 got %b/l%b want 0001/l0", bus_a.out_pix, bus_a.out_last);
    end
    step(1'b1, 4'h0, 4'hF, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus_a.out_pix !== 4'b0011 || bus_a.out_last !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_b1 got %b/l%b want 0011/l1", bus_a.out_pix, bus_a.out_last);
    end
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_done !== 1'b1 || bus_a.frame_count !== 16'd1) begin
      n_errors++;
      $display("FAIL rstmid_count got d%b c%0d want d1 c1", obs_done, bus_a.frame_count);
    end
  endtask

  // Reference: beats since reset give frame position and LFSR step count.
  task automatic test_random();
    int          n_acc;
    logic [31:0] lfsr;
    logic [1:0]  fmode;
    logic        fnoise;
    logic        e_valid;
    logic [3:0]  e_pix;
    logic        e_last;
    logic [15:0] e_cnt;
    logic        iv, ordy, ne, acc, hs, e_rdy, e_done;
    logic [3:0]  s, w;
    logic [1:0]  m;
    do_reset();
    n_acc = 0; lfsr = 32'h1; fmode = 2'd0; fnoise = 1'b0;
    e_valid = 1'b0; e_pix = 4'h0; e_last = 1'b0; e_cnt = 16'd0;
    for (int i = 0; i < 600; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      s    = 4'($urandom);
      w    = 4'($urandom);
      m    = 2'($urandom);
      ne   = 1'($urandom);
      e_rdy  = !e_valid || ordy;
      hs     = e_valid && ordy;
      e_done = hs && e_last;
      acc    = iv && e_rdy;
      step(iv, s, w, m, ne, ordy);
      n_checks++;
      if (obs_rdy !== e_rdy || obs_done !== e_done) begin
        n_errors++;
        $display("FAIL rand_hs cyc %0d got r%b d%b want r%b d%b",
                 i, obs_rdy, obs_done, e_rdy, e_done);
      end
      if (e_done) e_cnt = e_cnt + 16'd1;
      if (acc) begin
        if (n_acc % 2 == 0) begin
          fmode  = m;
          fnoise = ne;
        end
        e_pix   = ref_comp(fmode, s, w) ^ (fnoise ? lfsr[3:0] : 4'h0);
        e_last  = (n_acc % 2 == 1);
        lfsr    = lfsr_adv(lfsr);
        n_acc   = n_acc + 1;
        e_valid = 1'b1;
      end else if (hs) begin
        e_valid = 1'b0;
      end
      n_checks++;
      if (bus_a.out_valid !== e_valid || bus_a.frame_count !== e_cnt ||
          (e_valid && (bus_a.out_pix !== e_pix || bus_a.out_last !== e_last))) begin
        n_errors++;
        $display("FAIL rand_out cyc %0d got v%b p%b l%b c%0d want v%b p%b l%b c%0d",
                 i, bus_a.out_valid, bus_a.out_pix, bus_a.out_last,
                 bus_a.frame_count, e_valid, e_pix, e_last, e_cnt);
      end
    end
    step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
  endtask

  // Single-beat frames: every beat is first and last; 65536 frames wrap.
  task automatic test_wrap();
    bus_b.in_seg       = 8'hA5;
    bus_b.in_wm        = 8'h0F;
    bus_b.cfg_mode     = 2'd0;
    bus_b.cfg_noise_en = 1'b0;
    bus_b.out_ready    = 1'b1;
    bus_b.in_valid     = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_last !== 1'b1 ||
        bus_b.out_pix !== 8'hAF) begin
      n_errors++;
      $display("FAIL wrap_first got v%b l%b p%h want v1 l1 pAF",
               bus_b.out_valid, bus_b.out_last, bus_b.out_pix);
    end
    bus_b.cfg_mode = 2'd1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_b.out_pix !== 8'hAA || bus_b.frame_count !== 16'd1) begin
      n_errors++;
      $display("FAIL wrap_mode got p%h c%0d want pAA c1",
               bus_b.out_pix, bus_b.frame_count);
    end
    bus_b.cfg_mode = 2'd0;
    for (int i = 2; i < 65536; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus_b.frame_count !== 16'hFFFF) begin
      n_errors++; $display("FAIL wrap_ffff got %h want ffff", bus_b.frame_count);
    end
    bus_b.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus_b.frame_done !== 1'b1) begin
      n_errors++; $display("FAIL wrap_done got %b want 1", bus_b.frame_done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_b.frame_count !== 16'd0 || bus_b.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_zero got c%h v%b want c0 v0",
               bus_b.frame_count, bus_b.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_seg = '0; bus_a.in_wm = '0;
    bus_a.cfg_mode = 2'd0; bus_a.cfg_noise_en = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_seg = '0; bus_b.in_wm = '0;
    bus_b.cfg_mode = 2'd0; bus_b.cfg_noise_en = 1'b0; bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_modes();
    test_noise();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
